// File: rtl/pacman_gfx_pkg.sv
// Shared graphics definitions for the pacman display blocks: palette
// constants, the 16x16 life icon bitmap and the lives animation state type.
package pacman_gfx_pkg;

  localparam logic [7:0] YLW = 8'b11111100;
  localparam logic [7:0] BLK = 8'h00;

  // Row-major 16x16 bitmap; bit index = px + 16*py, index 0 is top-left.
  // Listed from row 15 (MSBs) down to row 0 (LSBs); bit n of a row is column n.
  localparam logic [255:0] LIFE_SPRITE = {
    16'h0000, 16'h07E0, 16'h1FF8, 16'h3FFC,
    16'h3FFC, 16'h7FFE, 16'h1FFE, 16'h07FE,
    16'h07FE, 16'h1FFE, 16'h7FFE, 16'h3FFC,
    16'h3FFC, 16'h1FF8, 16'h07E0, 16'h0000
  };

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BLINK_LOSS = 2'd1,
    BLINK_GAIN = 2'd2
  } lives_state_e;

endpackage

// File: rtl/life_sprite_rom.sv
// Combinational lookup of one pixel of the life icon bitmap.
module life_sprite_rom
  import pacman_gfx_pkg::*;
(
  input  logic [3:0] px,
  input  logic [3:0] py,
  output logic       pix
);

  // Row-major addressing: row selects the upper nibble of the bit index.
  always_comb begin
    pix = LIFE_SPRITE[{py, px}];
  end

endmodule

// File: rtl/graphics_lives_anim.sv
// Lives icon strip renderer with optional blink animation on count changes.
// Build macro GRAPHICS_LIVES_BLINK_EN enables the blink animation; without it
// the displayed count follows the target on every frame_tick.
module graphics_lives_anim
  import pacman_gfx_pkg::*;
#(
  parameter int unsigned MAX_LIVES     = 5,
  parameter int unsigned X_OFFSET      = 8,
  parameter int unsigned Y_OFFSET      = 296,
  parameter int unsigned BLINK_PERIOD  = 8,
  parameter int unsigned BLINK_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] xpos,
  input  logic [8:0] ypos,
  input  logic [2:0] lives,
  input  logic       load,
  input  logic       frame_tick,
  output logic [7:0] color,
  output logic       busy
);

  logic [2:0] target;
  logic [2:0] disp_q, disp_d;
  logic       anim_active;
  logic [2:0] anim_slot;
  logic       anim_phase;

  logic       in_region;
  logic [8:0] dx;
  logic [4:0] slot;
  logic [3:0] px, py;
  logic       visible;
  logic       sprite_bit;
  logic [7:0] color_q, color_d;

  // Saturate the requested count to the number of slots.
  always_comb begin
    target = (lives > 3'(MAX_LIVES)) ? 3'(MAX_LIVES) : lives;
  end

  // Displayed count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) disp_q <= '0;
    else     disp_q <= disp_d;
  end

`ifdef GRAPHICS_LIVES_BLINK_EN
  localparam int unsigned TICK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam int unsigned TOG_W  = $clog2(BLINK_TOGGLES);

  lives_state_e       state_q, state_d;
  logic [2:0]         anim_idx_q, anim_idx_d;
  logic               phase_q, phase_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [TOG_W-1:0]   tog_q, tog_d;

  // Animation state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      anim_idx_q <= '0;
      phase_q    <= 1'b0;
      tick_q     <= '0;
      tog_q      <= '0;
    end else begin
      state_q    <= state_d;
      anim_idx_q <= anim_idx_d;
      phase_q    <= phase_d;
      tick_q     <= tick_d;
      tog_q      <= tog_d;
    end
  end

  // Next-state: start one-life steps from IDLE, count ticks/toggles while blinking.
  always_comb begin
    state_d    = state_q;
    disp_d     = disp_q;
    anim_idx_d = anim_idx_q;
    phase_d    = phase_q;
    tick_d     = tick_q;
    tog_d      = tog_q;
    if (load) begin
      state_d = IDLE;
      disp_d  = target;
      phase_d = 1'b0;
      tick_d  = '0;
      tog_d   = '0;
    end else if (frame_tick) begin
      unique case (state_q)
        IDLE: begin
          if (target < disp_q) begin
            anim_idx_d = disp_q - 3'd1;
            phase_d    = 1'b0;
            tick_d     = '0;
            tog_d      = '0;
            state_d    = BLINK_LOSS;
          end else if (target > disp_q) begin
            anim_idx_d = disp_q;
            phase_d    = 1'b0;
            tick_d     = '0;
            tog_d      = '0;
            state_d    = BLINK_GAIN;
          end
        end
        BLINK_LOSS, BLINK_GAIN: begin
          if (tick_q == TICK_W'(BLINK_PERIOD - 1)) begin
            tick_d = '0;
            // Final toggle ends the step instead of flipping the phase.
            if (tog_q == TOG_W'(BLINK_TOGGLES - 1)) begin
              tog_d   = '0;
              state_d = IDLE;
              disp_d  = (state_q == BLINK_LOSS) ? disp_q - 3'd1 : disp_q + 3'd1;
            end else begin
              tog_d   = tog_q + TOG_W'(1);
              phase_d = ~phase_q;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs consumed by the pixel path.
  always_comb begin
    anim_active = (state_q != IDLE);
    anim_slot   = anim_idx_q;
    anim_phase  = phase_q;
    busy        = anim_active;
  end
`else
  // Displayed count tracks the target once per frame; load wins.
  always_comb begin
    disp_d = disp_q;
    if (load || frame_tick) disp_d = target;
  end

  // No animation in this build.
  always_comb begin
    anim_active = 1'b0;
    anim_slot   = '0;
    anim_phase  = 1'b0;
    busy        = 1'b0;
  end
`endif

  life_sprite_rom u_rom (
    .px  (px),
    .py  (py),
    .pix (sprite_bit)
  );

  // Pixel decode: region test, slot/pixel offsets and slot visibility.
  always_comb begin
    in_region = ({1'b0, xpos} >= 10'(X_OFFSET)) &&
                ({1'b0, xpos} <  10'(X_OFFSET + 16 * MAX_LIVES)) &&
                ({1'b0, ypos} >= 10'(Y_OFFSET)) &&
                ({1'b0, ypos} <  10'(Y_OFFSET + 16));
    dx   = xpos - 9'(X_OFFSET);
    slot = dx[8:4];
    px   = dx[3:0];
    py   = ypos[3:0] - 4'(Y_OFFSET);
    // The animated slot shows only in phase 1, for both loss and gain.
    if (anim_active && (slot == {2'b00, anim_slot})) visible = anim_phase;
    else                                              visible = (slot < {2'b00, disp_q});
    color_d = (in_region && visible && sprite_bit) ? YLW : BLK;
  end

  // Registered colour output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) color_q <= BLK;
    else     color_q <= color_d;
  end

  assign color = color_q;

endmodule
